// File: rtl/audiomini_pll_pkg.sv
// Shared types and 12.288 MHz default timing for the audio-mini PLL lock supervisor.
package audiomini_pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 64;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 12288;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOSS_FILTER_CYCLES  = 4;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_CNT_W               = 8;

  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic pll_ready;
    logic pll_fail;
  } pll_ctl_t;

  localparam pll_ctl_t CTL_RESET = '{pll_rst: 1'b1, sys_rst: 1'b1, pll_ready: 1'b0, pll_fail: 1'b0};

  function automatic pll_ctl_t ctl_for(pll_state_t s);
    pll_ctl_t c;
    c = CTL_RESET;
    case (s)
      WAIT_LOCK, STABLE: c = '{pll_rst: 1'b0, sys_rst: 1'b1, pll_ready: 1'b0, pll_fail: 1'b0};
      RUN:               c = '{pll_rst: 1'b0, sys_rst: 1'b0, pll_ready: 1'b1, pll_fail: 1'b0};
      FAIL:              c = '{pll_rst: 1'b1, sys_rst: 1'b1, pll_ready: 1'b0, pll_fail: 1'b1};
      default:           c = CTL_RESET;
    endcase
    return c;
  endfunction

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/audiomini_pll_lock_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor (slave) and its user (master).
interface audiomini_pll_lock_supervisor_if #(parameter int CNT_W = 8);
  logic             restart;
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rst;
  logic             pll_ready;
  logic             pll_fail;
  logic [2:0]       state_o;
  logic [1:0]       retry_cnt;
  logic [CNT_W-1:0] loss_cnt;

  modport master (
    output restart, pll_locked,
    input  pll_rst, sys_rst, pll_ready, pll_fail, state_o, retry_cnt, loss_cnt
  );

  modport slave (
    input  restart, pll_locked,
    output pll_rst, sys_rst, pll_ready, pll_fail, state_o, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/audiomini_bit_sync.sv
// Two-flop synchroniser for a single asynchronous level, cleared to 0 by reset.
module audiomini_bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/audiomini_pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock and gates the 98.304 MHz domain reset; refclk domain only.
//  state     | meaning
//  RESET_PLL | PLL held in reset for the pulse time
//  WAIT_LOCK | PLL released, waiting for lock or timeout
//  STABLE    | lock seen, counting consecutive locked cycles
//  RUN       | downstream released, filtering lock loss
//  FAIL      | retries exhausted, waiting for restart
module audiomini_pll_lock_supervisor
  import audiomini_pll_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOSS_FILTER_CYCLES  = DEF_LOSS_FILTER_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic                         refclk,
  input  logic                         rst,
  audiomini_pll_lock_supervisor_if.slave bus
);

  localparam int MAX_CYC = max_int(max_int(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                   max_int(LOCK_STABLE_CYCLES, LOSS_FILTER_CYCLES));
  localparam int TW = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0]    RST_LAST    = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST     = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    LOSS_LAST   = TW'(LOSS_FILTER_CYCLES - 1);
  localparam logic [TW-1:0]    T_ONE       = TW'(1);
  localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  pll_state_t       state;
  pll_ctl_t         ctl;
  logic [TW-1:0]    timer;
  logic [1:0]       retry_cnt;
  logic [CNT_W-1:0] loss_cnt;
  logic             lk;

  audiomini_bit_sync u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (lk)
  );

  // The shared timer doubles as the lock-loss filter while in RUN.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= RESET_PLL;
      ctl       <= CTL_RESET;
      timer     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else if (bus.restart) begin
      state     <= RESET_PLL;
      ctl       <= CTL_RESET;
      timer     <= '0;
      retry_cnt <= '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (timer == RST_LAST) begin
            state <= WAIT_LOCK;
            ctl   <= ctl_for(WAIT_LOCK);
            timer <= '0;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state <= STABLE;
            ctl   <= ctl_for(STABLE);
            timer <= '0;
          end else if (timer == TO_LAST) begin
            timer <= '0;
            if (retry_cnt == RETRY_MAX) begin
              state <= FAIL;
              ctl   <= ctl_for(FAIL);
            end else begin
              state     <= RESET_PLL;
              ctl       <= CTL_RESET;
              retry_cnt <= retry_cnt + 2'd1;
            end
          end else begin
            timer <= timer + T_ONE;
          end
        end
        STABLE: begin
          if (!lk) begin
            state <= WAIT_LOCK;
            ctl   <= ctl_for(WAIT_LOCK);
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            state     <= RUN;
            ctl       <= ctl_for(RUN);
            timer     <= '0;
            retry_cnt <= '0;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        RUN: begin
          if (lk) begin
            timer <= '0;
          end else if (timer == LOSS_LAST) begin
            state <= RESET_PLL;
            ctl   <= CTL_RESET;
            timer <= '0;
            if (loss_cnt != '1) loss_cnt <= loss_cnt + L_ONE;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        FAIL: begin
          timer <= '0;
        end
        default: begin
          state <= RESET_PLL;
          ctl   <= CTL_RESET;
          timer <= '0;
        end
      endcase
    end
  end

  assign bus.pll_rst   = ctl.pll_rst;
  assign bus.sys_rst   = ctl.sys_rst;
  assign bus.pll_ready = ctl.pll_ready;
  assign bus.pll_fail  = ctl.pll_fail;
  assign bus.state_o   = state;
  assign bus.retry_cnt = retry_cnt;
  assign bus.loss_cnt  = loss_cnt;

endmodule
